// File: rtl/adder8bit_pkg.sv
// -----------------------------------------------------------------------------
// adder8bit_pkg
// Shared constants for the AXI4-Lite 8-bit adder slave: word-register
// indices (address bits [3:2]), CTRL/RESULT bit positions, the add FSM
// state type and the AXI OKAY response code.
// -----------------------------------------------------------------------------
package adder8bit_pkg;

    // Word indices taken from address bits [3:2]
    localparam logic [1:0] REG_OPA    = 2'd0;
    localparam logic [1:0] REG_OPB    = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_RESULT = 2'd3;

    // CTRL bit positions
    localparam int CTRL_START  = 0;
    localparam int CTRL_CIN    = 1;
    localparam int CTRL_IRQ_EN = 2;

    // RESULT bit positions (SUM occupies [7:0])
    localparam int RES_COUT = 8;
    localparam int RES_DONE = 16;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder8bit_core.sv
// -----------------------------------------------------------------------------
// adder8bit_core
// Registered 8-bit adder. On a clock edge with start high it latches
// {cout,sum} = a + b + cin and raises valid. valid is sticky until clear;
// clear has priority over start so a control write always drops it.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start, clear      latch a new result / drop valid
//   a, b, cin         operands and carry-in
//   sum, cout, valid  registered result and completion flag
// -----------------------------------------------------------------------------
module adder8bit_core (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       clear,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout,
    output logic       valid
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum   <= '0;
            cout  <= 1'b0;
            valid <= 1'b0;
        end else begin
            if (start) begin
                {cout, sum} <= {1'b0, a} + {1'b0, b} + {8'd0, cin};
            end
            if (clear) begin
                valid <= 1'b0;
            end else if (start) begin
                valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder8bit_axil_slave.sv
// -----------------------------------------------------------------------------
// adder8bit_axil_slave
// AXI4-Lite slave exposing an 8-bit adder: OPA (0x0), OPB (0x4),
// CTRL (0x8: START self-clearing, CIN, IRQ_EN), RESULT (0xC, read-only:
// SUM[7:0], COUT[8], DONE[16]). A START write moves IDLE -> CALC for one
// cycle, then DONE; the result lands two cycles after write acceptance.
// Optional feature: define ADDER8_IRQ_EN to add CTRL.IRQ_EN and a registered
// level interrupt irq = DONE & IRQ_EN. Without it, irq is absent and CTRL
// bit2 reads 0.
// Ports:
//   S_AXI_ACLK / S_AXI_ARESETN   clock, synchronous active-low reset
//   S_AXI_AW* / S_AXI_W* / S_AXI_B*   write address, data, response
//   S_AXI_AR* / S_AXI_R*              read address and data
//   irq                               interrupt (ADDER8_IRQ_EN only)
// -----------------------------------------------------------------------------
module adder8bit_axil_slave
    import adder8bit_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
`ifdef ADDER8_IRQ_EN
    ,
    output logic                            irq
`endif
);

    logic       [7:0]                    opa;
    logic       [7:0]                    opb;
    logic                                cin;
`ifdef ADDER8_IRQ_EN
    logic                                irq_en;
`endif
    state_t                              state;
    logic       [7:0]                    sum;
    logic                                cout;
    logic                                done;
    logic                                wr_en;
    logic       [1:0]                    wr_idx;
    logic                                ctrl_wr;
    logic                                start_req;
    logic       [C_S_AXI_DATA_WIDTH-1:0] rd_mux;
    logic                                unused_bits;

    // Ready pulses only when both channels were valid at the previous edge,
    // so the write itself happens on the edge that ends the ready pulse.
    assign wr_en     = S_AXI_AWREADY & S_AXI_WREADY & S_AXI_AWVALID & S_AXI_WVALID;
    assign wr_idx    = S_AXI_AWADDR[3:2];
    assign ctrl_wr   = wr_en & (wr_idx == REG_CTRL);
    assign start_req = ctrl_wr & S_AXI_WSTRB[0] & S_AXI_WDATA[CTRL_START];

    assign S_AXI_BRESP = RESP_OKAY;
    assign S_AXI_RRESP = RESP_OKAY;

    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0],
                           S_AXI_ARADDR[1:0], S_AXI_WDATA[C_S_AXI_DATA_WIDTH-1:8],
                           S_AXI_WSTRB[C_S_AXI_DATA_WIDTH/8-1:1]};

    // Write channel, register file and add FSM
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            opa           <= '0;
            opb           <= '0;
            cin           <= 1'b0;
`ifdef ADDER8_IRQ_EN
            irq_en        <= 1'b0;
`endif
            state         <= ST_IDLE;
        end else begin
            if (!S_AXI_AWREADY && S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_BVALID) begin
                S_AXI_AWREADY <= 1'b1;
                S_AXI_WREADY  <= 1'b1;
            end else begin
                S_AXI_AWREADY <= 1'b0;
                S_AXI_WREADY  <= 1'b0;
            end

            if (wr_en) begin
                S_AXI_BVALID <= 1'b1;
            end else if (S_AXI_BREADY) begin
                S_AXI_BVALID <= 1'b0;
            end

            if (wr_en && S_AXI_WSTRB[0]) begin
                case (wr_idx)
                    REG_OPA:  opa <= S_AXI_WDATA[7:0];
                    REG_OPB:  opb <= S_AXI_WDATA[7:0];
                    REG_CTRL: begin
                        cin    <= S_AXI_WDATA[CTRL_CIN];
`ifdef ADDER8_IRQ_EN
                        irq_en <= S_AXI_WDATA[CTRL_IRQ_EN];
`endif
                    end
                    default: ;
                endcase
            end

            case (state)
                ST_IDLE: if (start_req) state <= ST_CALC;
                ST_CALC: state <= ST_DONE;
                ST_DONE: if (start_req) state <= ST_CALC;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // DONE lives in the core; any CTRL write clears it, even mid-calculation
    adder8bit_core u_core (
        .clk   (S_AXI_ACLK),
        .rst_n (S_AXI_ARESETN),
        .start (state == ST_CALC),
        .clear (ctrl_wr),
        .a     (opa),
        .b     (opb),
        .cin   (cin),
        .sum   (sum),
        .cout  (cout),
        .valid (done)
    );

    always_comb begin
        rd_mux = '0;
        case (S_AXI_ARADDR[3:2])
            REG_OPA:  rd_mux[7:0] = opa;
            REG_OPB:  rd_mux[7:0] = opb;
            REG_CTRL: begin
                rd_mux[CTRL_CIN] = cin;
`ifdef ADDER8_IRQ_EN
                rd_mux[CTRL_IRQ_EN] = irq_en;
`endif
            end
            default: begin
                rd_mux[7:0]      = sum;
                rd_mux[RES_COUT] = cout;
                rd_mux[RES_DONE] = done;
            end
        endcase
    end

    // Read channel; RDATA captures register state from before this edge
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
        end else begin
            S_AXI_ARREADY <= !S_AXI_ARREADY && S_AXI_ARVALID && !S_AXI_RVALID;
            if (S_AXI_ARREADY && S_AXI_ARVALID) begin
                S_AXI_RVALID <= 1'b1;
                S_AXI_RDATA  <= rd_mux;
            end else if (S_AXI_RREADY) begin
                S_AXI_RVALID <= 1'b0;
            end
        end
    end

`ifdef ADDER8_IRQ_EN
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            irq <= 1'b0;
        end else begin
            irq <= done & irq_en;
        end
    end
`endif

endmodule

// File: doc/adder8bit_axil_slave.md
ADDER8BIT_AXIL_SLAVE -- requirements
Module: adder8bit_axil_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width; only 32 is supported.
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, byte address width covering 4 word registers.
REQ-003 SHALL have port S_AXI_ACLK, input, 1: the single clock; all logic is rising-edge.
REQ-004 SHALL have port S_AXI_ARESETN, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have ports S_AXI_AWADDR (in, 4), S_AXI_AWPROT (in, 3), S_AXI_AWVALID (in, 1) and S_AXI_AWREADY (out, 1): write address channel.
REQ-006 SHALL have ports S_AXI_WDATA (in, 32), S_AXI_WSTRB (in, 4), S_AXI_WVALID (in, 1) and S_AXI_WREADY (out, 1): write data channel.
REQ-007 SHALL have ports S_AXI_BRESP (out, 2), S_AXI_BVALID (out, 1) and S_AXI_BREADY (in, 1): write response channel.
REQ-008 SHALL have ports S_AXI_ARADDR (in, 4), S_AXI_ARPROT (in, 3), S_AXI_ARVALID (in, 1) and S_AXI_ARREADY (out, 1): read address channel.
REQ-009 SHALL have ports S_AXI_RDATA (out, 32), S_AXI_RRESP (out, 2), S_AXI_RVALID (out, 1) and S_AXI_RREADY (in, 1): read data channel.
REQ-010 SHALL have port irq, output, 1: level interrupt, present only under ADDER8_IRQ_EN.

Function
REQ-011 SHALL implement register map 0x0 OPA (RW, bits[7:0]), 0x4 OPB (RW, bits[7:0]), 0x8 CTRL (RW, bit0 START self-clearing, bit1 CIN, bit2 IRQ_EN), 0xC RESULT (RO: bits[7:0] SUM, bit8 COUT, bit16 DONE).
REQ-012 SHALL decode only AWADDR[3:2] and ARADDR[3:2]; the low two address bits are ignored.
REQ-013 SHALL accept a write only when AWVALID and WVALID are both high and BVALID is low, pulsing AWREADY and WREADY together for exactly one cycle.
REQ-014 SHALL assert BVALID with BRESP=OKAY in the cycle after write acceptance and hold it until BREADY is sampled high.
REQ-015 SHALL apply WSTRB per byte; unwritten bytes keep their values, and bits above [7:0] in OPA/OPB read as 0.
REQ-016 SHALL ignore writes to RESULT while still responding OKAY; a DONE clear requires a write to CTRL.
REQ-017 SHALL accept a read when ARVALID is high and RVALID is low, pulsing ARREADY for one cycle, then assert RVALID with RRESP=OKAY the next cycle and hold RDATA/RVALID stable until RREADY.
REQ-018 SHALL, on a CTRL write with WDATA[0]=1 and WSTRB[0]=1, start an add: state IDLE -> CALC (1 cycle) -> DONE_ST; RESULT and DONE update 2 cycles after write acceptance.
REQ-019 SHALL compute {COUT,SUM} = OPA + OPB + CIN (9-bit), with 0xFF+0xFF+1 wrapping to SUM=0xFF, COUT=1.
REQ-020 SHALL clear DONE on any CTRL write; a START received in CALC is ignored, while a START in DONE_ST restarts the add.
REQ-021 SHALL give a read of RESULT in the same cycle DONE sets the old value; the new value appears on the next read.
REQ-022 SHALL service a simultaneous read and write independently; a read of a register written in the same cycle returns the pre-write value.

Reset
REQ-023 SHALL, while S_AXI_ARESETN=0 at a clock edge, clear all registers, the FSM (to IDLE), AWREADY/WREADY/ARREADY/BVALID/RVALID, BRESP/RRESP/RDATA and irq to 0.
REQ-024 SHALL abandon any in-flight handshake or add when reset is applied mid-operation; no response is issued after reset.

Configuration
REQ-025 SHALL, when ADDER8_IRQ_EN is defined, include irq = DONE & IRQ_EN, registered.
REQ-026 SHALL, when ADDER8_IRQ_EN is undefined, omit the irq port and make CTRL bit2 read as 0 and ignore writes.

Structure
REQ-027 SHALL place the register offsets, CTRL/RESULT bit positions, FSM state enum and the RESP_OKAY constant in the package adder8bit_pkg.
REQ-028 SHALL instantiate a sub-module adder8bit_core (registered 8-bit add with start/valid) from the slave.

Verification
REQ-029 SHALL cover: write OPA=0x12, OPB=0x34 then CTRL=0x1 -> RESULT reads 0x00010046.
REQ-030 SHALL cover: OPA=0xFF, OPB=0xFF, CTRL=0x3 -> RESULT reads 0x000101FF.
REQ-031 SHALL cover: write OPA=0xAABBCCDD with WSTRB=0x2 -> OPA reads 0x00000000; a second write of 0x5A with WSTRB=0x1 -> OPA reads 0x0000005A.
REQ-032 SHALL cover: BREADY held low 10 cycles after a write -> BVALID stays high, a second write is not accepted, and it is accepted after BREADY.
REQ-033 SHALL cover: reset asserted in CALC -> RESULT reads 0 and DONE=0 after release.
REQ-034 SHALL cover, with ADDER8_IRQ_EN: CTRL=0x5 -> irq rises 3 cycles after acceptance, and a CTRL=0x0 write drops it.
